// File: rtl/dsa_arb_pkg.sv
// Shared types and helpers for the pixel-memory arbiter.
package dsa_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int REQ_HOST  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_WB    = 2;

  // Width of a requester id; never below one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsa_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module dsa_rr_pick
  import dsa_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand_s;
  logic            hit_s;

  // Scan upward from ptr with wrap; the first valid candidate wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s         = ID_W'((int'(ptr) + k) % NUM_REQ);
      hit_s          = !any && valid[cand_s];
      onehot[cand_s] = onehot[cand_s] | hit_s;
      idx            = hit_s ? cand_s : idx;
      any            = any | hit_s;
    end
  end

endmodule

// File: rtl/dsa_mem_arbiter.sv
// Round-robin, burst-locking arbiter for the single-port pixel BRAM.
// Grants and memory strobes are combinational (zero-cycle arbitration);
// read responses return in order through an RD_LATENCY-deep tag pipe.
// Optional feature macro: DSA_ARB_STATS_EN adds saturating grant/stall counters.
module dsa_mem_arbiter
  import dsa_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      arb_busy,
  input  logic                      stat_clr,
  output logic [NUM_REQ*32-1:0]     stat_grants,
  output logic [NUM_REQ*32-1:0]     stat_stalls
);

  localparam int              ID_W    = id_width(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t                state_r;
  logic [ID_W-1:0]       owner_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [NUM_REQ-1:0]    pick_onehot_s;
  logic [ID_W-1:0]       pick_idx_s;
  logic                  pick_any_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [ID_W-1:0]       gnt_idx_s;
  logic                  beat_s;
  logic                  rd_push_s;
  logic [RD_LATENCY-1:0] tag_vld_r;
  logic [ID_W-1:0]       tag_id_r [RD_LATENCY];

  // Round-robin successor of a requester id
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  dsa_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Grant selection: free round-robin choice when idle, owner only while locked
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = pick_idx_s;
    beat_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        gnt_s     = pick_onehot_s;
        gnt_idx_s = pick_idx_s;
        beat_s    = pick_any_s;
      end
      ST_LOCKED: begin
        gnt_s[owner_r] = req_valid[owner_r];
        gnt_idx_s      = owner_r;
        beat_s         = req_valid[owner_r];
      end
      default: begin
        gnt_s     = '0;
        gnt_idx_s = pick_idx_s;
        beat_s    = 1'b0;
      end
    endcase
  end

  assign rd_push_s = beat_s & ~req_we[gnt_idx_s];

  // Put the granted beat straight onto the memory port in the same cycle
  always_comb begin
    req_gnt = gnt_s;
    mem_en  = beat_s;
    if (beat_s) begin
      mem_we    = req_we[gnt_idx_s];
      mem_addr  = req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
    end else begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Burst lock and round-robin pointer; the pointer moves past whoever ends a burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (beat_s) begin
            if (req_last[gnt_idx_s]) begin
              rr_ptr_r <= next_id(gnt_idx_s);
            end else begin
              state_r <= ST_LOCKED;
              owner_r <= gnt_idx_s;
            end
          end
        end
        ST_LOCKED: begin
          if (beat_s && req_last[owner_r]) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= next_id(owner_r);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read tag pipe: carries the issuing id alongside the BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_r <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_id_r[i] <= '0;
    end else begin
      tag_vld_r[0] <= rd_push_s;
      tag_id_r[0]  <= gnt_idx_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
    end
  end

  // Route returning read data to the requester named by the oldest tag
  always_comb begin
    rsp_valid = '0;
    if (tag_vld_r[RD_LATENCY-1]) begin
      rsp_valid[tag_id_r[RD_LATENCY-1]] = 1'b1;
      rsp_rdata = mem_rdata;
    end else begin
      rsp_rdata = '0;
    end
  end

  assign arb_busy = (state_r == ST_LOCKED) | (|tag_vld_r);

`ifdef DSA_ARB_STATS_EN
  logic [31:0] grant_cnt_r [NUM_REQ];
  logic [31:0] stall_cnt_r [NUM_REQ];

  // Saturating increment
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Per-requester beat and stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_r[i] <= 32'd0;
        stall_cnt_r[i] <= 32'd0;
      end
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_r[i] <= 32'd0;
        stall_cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_r[i] <= sat_inc(grant_cnt_r[i], gnt_s[i]);
        stall_cnt_r[i] <= sat_inc(stall_cnt_r[i], req_valid[i] & ~gnt_s[i]);
      end
    end
  end

  // Flatten the counters onto the packed stat ports
  always_comb begin
    stat_grants = '0;
    stat_stalls = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*32 +: 32] = grant_cnt_r[i];
      stat_stalls[i*32 +: 32] = stall_cnt_r[i];
    end
  end
`else
  logic unused_stat_clr_s;
  assign unused_stat_clr_s = stat_clr;
  assign stat_grants       = '0;
  assign stat_stalls       = '0;
`endif

endmodule
